accl_pair_sequencer: RTL and testbench
======================================

Name: accl_pair_sequencer

Overview:
- Generates the (i, j) body-pair read stream feeding the acceleration pipeline in CALC_ACCEL: addresses for the x/y/m RAMs, one pair per cycle, j fastest.
- Carries a matching tag (i, j, first, last, valid) through a fixed-latency delay line so each tag leaves exactly when the acceleration pipeline's result for that pair appears.
- The downstream velocity update uses the tags as write enables and addresses, replacing the ad-hoc timer/counter logic in the top-level wrapper.

Parameters:
- BODIES, 512, maximum body count.
- BODY_W, $clog2(BODIES), body address width.
- RD_LAT, 1, RAM read latency in cycles.
- ACCL_LAT, 123, acceleration pipeline latency in cycles.
- PIPE_LAT, RD_LAT+ACCL_LAT, total tag delay (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one full pass; sampled only in IDLE.
- abort  in  1  cancel the pass (software dropped go).
- n_bodies  in  BODY_W+1  active body count N, 0..BODIES; sampled with start.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when the pass completes.
- rd_en  out  1  pair read issued this cycle.
- rd_addr_i  out  BODY_W  address of body i (x1/y1 port).
- rd_addr_j  out  BODY_W  address of body j (x2/y2/m port).
- out_valid  out  1  tag valid, aligned with the acceleration result.
- out_i  out  BODY_W  tag i.
- out_j  out  BODY_W  tag j.
- out_first  out  1  tag is first pair of row i (j==0).
- out_last  out  1  tag is last pair of row i (j==N-1).

Behaviour:
- Reset: async. State IDLE. Counters, N latch and the whole delay line cleared. All outputs 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 at cycle t latches N.
  - N=0: done pulses at t+1; state stays IDLE; nothing is issued.
  - Otherwise ISSUE begins at t+1.
- ISSUE:
  - rd_en=1 every cycle. Addresses come directly from the registered i/j counters.
  - Pair k (k = i*N + j, 0..N*N-1) is issued at cycle t+1+k.
  - j increments and wraps N-1→0, then i increments.
  - After pair (N-1, N-1) is issued, go to DRAIN; rd_en=0 from the next cycle.
- DRAIN:
  - A counter runs PIPE_LAT cycles; the final tag exits at t+N*N+PIPE_LAT.
  - Next cycle: done=1 for one cycle, busy=0, state IDLE.
- Delay line:
  - PIPE_LAT-stage shift register of {valid, i, j, first, last}, advancing every cycle with no stall.
  - Issued pair k appears on out_* exactly PIPE_LAT cycles after its rd_en cycle.
  - Stages fill with valid=0 when rd_en=0.
- busy is 1 from t+1 through the final tag-exit cycle.
- start while busy: ignored. A change of n_bodies mid-pass has no effect.
- abort (any state, highest priority):
  - Next cycle: state IDLE, counters zero, every delay-line valid bit cleared.
  - done is not pulsed.
  - abort and start in the same IDLE cycle: abort wins, no pass.
- N=BODIES: counters must not overflow. Width is BODY_W for i/j and 2*BODY_W+1 for any pair count.
- out_first and out_last are both 1 when N=1.

Optional Feature:
- Macro: PAIR_SKIP_SELF_EN.
- Defined: pairs with i==j are still issued and keep timing slots, but their tag valid bit is 0, so downstream never writes a self-interaction. out_first/out_last are computed on j as usual; consumers must handle a suppressed first/last slot by using out_first/out_last ungated by valid.
- Undefined: every issued pair has valid=1; the acceleration pipeline's divide-by-zero guard handles i==j.

Test Plan (bench uses ACCL_LAT=4, RD_LAT=1, PIPE_LAT=5):
- N=3, start at cycle 0:
  - rd_en cycles 1..9, addresses (0,0),(0,1),(0,2),(1,0)...(2,2).
  - out_valid cycles 6..14 with identical i/j; out_first at cycles 6,9,12; out_last at 8,11,14.
  - done at 15; busy 1..14.
- N=0, start → done at cycle 1, busy never 1, rd_en never 1.
- N=1 with PIPE_LAT=5, start at 0:
  - rd_en at cycle 1, tag at cycle 6 with first=last=1; done at 7.
  - out_valid=0 at cycle 6 with PAIR_SKIP_SELF_EN defined, 1 without.
- N=4, abort at cycle 7:
  - Cycle 8: state IDLE, busy=0, no further rd_en or out_valid, no done.
  - Fresh start at 10 reproduces the N=4 sequence from (0,0).
- N=BODIES=8 (bench override): 64 reads, last tag (7,7) at cycle 64+5, done at 70; start pulsed at cycle 20 has no effect.
- Async rst asserted mid-DRAIN: all outputs 0 immediately, no done. After release, start behaves as from power-up.

Source files
------------

// File: rtl/accl_pair_sequencer.sv
// accl_pair_sequencer: issues (i,j) body-pair reads for CALC_ACCEL and delays matching tags to the accel result.
// Optional PAIR_SKIP_SELF_EN: self pairs (i==j) keep their slot but carry valid=0.
module accl_pair_sequencer #(
   parameter int BODIES   = 512,
   parameter int BODY_W   = $clog2(BODIES),
   parameter int RD_LAT   = 1,
   parameter int ACCL_LAT = 123
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [BODY_W:0]   n_bodies,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [BODY_W-1:0] rd_addr_i,
   output logic [BODY_W-1:0] rd_addr_j,
   output logic              out_valid,
   output logic [BODY_W-1:0] out_i,
   output logic [BODY_W-1:0] out_j,
   output logic              out_first,
   output logic              out_last
);
   localparam int PIPE_LAT = RD_LAT + ACCL_LAT;
   localparam int CNT_W    = $clog2(PIPE_LAT + 1);
   localparam int TAG_W    = 2 * BODY_W + 3;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state, state_n;
   logic [BODY_W-1:0] i_q, i_n, j_q, j_n;
   logic [BODY_W:0]   n_q, n_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              done_n, j_last, i_last, valid_in;
   logic [TAG_W-1:0]  line [PIPE_LAT];

   // compare in BODY_W+1 bits so N=BODIES never wraps
   assign j_last = {1'b0, j_q} == n_q - 1'b1;
   assign i_last = {1'b0, i_q} == n_q - 1'b1;
   assign rd_en = state == ISSUE;
   assign busy = state != IDLE;
   assign rd_addr_i = i_q;
   assign rd_addr_j = j_q;
`ifdef PAIR_SKIP_SELF_EN
   assign valid_in = rd_en & ~abort & (i_q != j_q);
`else
   assign valid_in = rd_en & ~abort;
`endif
   assign {out_valid, out_i, out_j, out_first, out_last} = line[PIPE_LAT-1];

   always_comb begin
      state_n = state;
      i_n = i_q;
      j_n = j_q;
      n_n = n_q;
      cnt_n = cnt;
      done_n = 1'b0;
      if (abort) begin
         state_n = IDLE;
         i_n = '0;
         j_n = '0;
         cnt_n = '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               n_n = n_bodies;
               i_n = '0;
               j_n = '0;
               done_n = n_bodies == '0;
               state_n = n_bodies == '0 ? IDLE : ISSUE;
            end
            ISSUE: begin
               j_n = j_last ? '0 : j_q + 1'b1;
               i_n = j_last ? (i_last ? '0 : i_q + 1'b1) : i_q;
               state_n = j_last && i_last ? DRAIN : ISSUE;
               cnt_n = '0;
            end
            DRAIN: begin
               done_n = cnt == CNT_W'(PIPE_LAT - 1);
               state_n = done_n ? IDLE : DRAIN;
               cnt_n = done_n ? '0 : cnt + 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         i_q <= '0;
         j_q <= '0;
         n_q <= '0;
         cnt <= '0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         i_q <= i_n;
         j_q <= j_n;
         n_q <= n_n;
         cnt <= cnt_n;
         done <= done_n;
      end
   end

   // abort kills every in-flight tag by clearing its valid bit as it shifts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < PIPE_LAT; s++) line[s] <= '0;
      end else begin
         line[0] <= {valid_in, i_q, j_q, j_q == '0, j_last};
         for (int s = 1; s < PIPE_LAT; s++)
            line[s] <= {line[s-1][TAG_W-1] & ~abort, line[s-1][TAG_W-2:0]};
      end
   end
endmodule

// File: tb/tb_accl_pair_sequencer.sv
// tb_accl_pair_sequencer: scoreboard bench for accl_pair_sequencer with BODIES=8, PIPE_LAT=5.
module tb_accl_pair_sequencer;
   localparam int BW = 3;
   localparam int PL = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [BW:0]   n_bodies = '0;
   logic          busy, done, rd_en, out_valid, out_first, out_last;
   logic [BW-1:0] rd_addr_i, rd_addr_j, out_i, out_j;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_done = -1;
   int blo = 1;
   int bhi = 0;
   logic [31:0] rq[$];
   logic [31:0] tq[$];

   accl_pair_sequencer #(.BODIES(8), .RD_LAT(1), .ACCL_LAT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .n_bodies(n_bodies),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j),
      .out_valid(out_valid), .out_i(out_i), .out_j(out_j), .out_first(out_first), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      rq.delete();
      tq.delete();
      exp_done = -1;
      blo = 1;
      bhi = 0;
   endtask

   task automatic run_pass(input int n);
      int t = cyc;
      for (int k = 0; k < n * n; k++) begin
         int i = k / n;
         int j = k % n;
         rq.push_back({10'd0, 16'(t + 1 + k), 3'(i), 3'(j)});
`ifdef PAIR_SKIP_SELF_EN
         if (i != j)
`endif
         tq.push_back({8'd0, 16'(t + 1 + k + PL), 3'(i), 3'(j), j == 0, j == n - 1});
      end
      exp_done = n == 0 ? t + 1 : t + n * n + PL + 1;
      blo = t + 1;
      bhi = n == 0 ? t : t + n * n + PL;
      n_bodies = 4'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic finish_pass(input int n);
      repeat (n * n + PL + 3) tick();
      chk("rd_missing", rq.size(), 0);
      chk("tag_missing", tq.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rd_en) begin
         if (rq.size() == 0) chk("rd_extra", {10'd0, 16'(cyc), rd_addr_i, rd_addr_j}, 0);
         else chk("rd", {10'd0, 16'(cyc), rd_addr_i, rd_addr_j}, rq.pop_front());
      end
      if (out_valid) begin
         if (tq.size() == 0) chk("tag_extra", {8'd0, 16'(cyc), out_i, out_j, out_first, out_last}, 0);
         else chk("tag", {8'd0, 16'(cyc), out_i, out_j, out_first, out_last}, tq.pop_front());
      end
      chk("done", done, cyc == exp_done);
      chk("busy", busy, cyc >= blo && cyc <= bhi);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_outs", {rd_en, out_valid, done, rd_addr_i, rd_addr_j, out_i, out_j}, 0);
      tick();
      rst = 1'b0;
      tick();
      run_pass(3);
      finish_pass(3);
      run_pass(0);
      finish_pass(0);
      run_pass(1);
      finish_pass(1);
      begin
         int t = cyc;
         run_pass(4);
         while (cyc < t + 7) tick();
         abort = 1'b1;
         tick();
         abort = 1'b0;
         flush();
         bhi = t + 7;
         while (cyc < t + 10) tick();
         chk("abort_idle", busy, 0);
         run_pass(4);
         finish_pass(4);
      end
      abort = 1'b1;
      n_bodies = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      repeat (4) tick();
      begin
         int t = cyc;
         run_pass(8);
         while (cyc < t + 20) tick();
         n_bodies = 4'd3;
         start = 1'b1;
         tick();
         start = 1'b0;
         finish_pass(8);
      end
      begin
         int t = cyc;
         run_pass(2);
         while (cyc < t + 6) tick();
         rst = 1'b1;
         flush();
         #1;
         chk("rst_mid_busy", busy, 0);
         chk("rst_mid_outs", {rd_en, out_valid, done, out_i, out_j, out_first, out_last}, 0);
         repeat (2) tick();
         rst = 1'b0;
         tick();
         run_pass(3);
         finish_pass(3);
      end
      for (int r = 0; r < 2; r++) begin
         int n = $urandom_range(2, 7);
         run_pass(n);
         finish_pass(n);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
